pmsm_param: RTL and testbench
=============================

PMSM_PARAM -- requirements
Module: pmsm_param

Interface
REQ-001 Parameter NUM_STATES, default 4, SHALL set the trellis state count; legal values are powers of two from 2 to 64.
REQ-002 Parameter PM_W, default 4, SHALL set the metric width in bits; legal values are 3 to 12.
REQ-003 Parameter NORM_THRESH, default 8, SHALL set the normalization threshold; legal values are 1 to 2^PM_W-2.
REQ-004 Parameter INIT_STATE, default 0, SHALL set the state index seeded with metric 0 at frame start.
REQ-005 clk  input  1  SHALL be the only clock; all logic is rising-edge.
REQ-006 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-007 frame_start  input  1  SHALL re-seed the metric store for a new frame.
REQ-008 in_valid  input  1  SHALL qualify in_pm as one ACS step result.
REQ-009 in_pm  input  NUM_STATES*PM_W  SHALL carry the new metrics; state i occupies bits [i*PM_W +: PM_W].
REQ-010 out_pm  output  NUM_STATES*PM_W  SHALL carry the stored metrics, packed the same way as in_pm.
REQ-011 out_valid  output  1  SHALL pulse for one cycle when out_pm has been updated by an in_valid write.
REQ-012 min_pm  output  PM_W  SHALL carry the smallest stored metric.
REQ-013 min_state  output  log2(NUM_STATES)  SHALL carry the index of min_pm.
REQ-014 min_valid  output  1  SHALL be high while min_pm and min_state match out_pm.
REQ-015 norm_event  output  1  SHALL pulse for one cycle when a normalized write is stored.
REQ-016 step_cnt  output  16  SHALL count the in_valid writes stored since the last frame_start.

Function
REQ-017 INF SHALL be all-ones (2^PM_W-1), which denotes an unreachable state.
REQ-018 Seed values: state INIT_STATE SHALL be 0 and every other state SHALL be INF.
REQ-019 frame_start SHALL load the seed values, clear step_cnt and norm_pending, and suppress out_valid and norm_event for that cycle.
REQ-020 frame_start SHALL have priority over a simultaneous in_valid; the in_valid data is dropped.
REQ-021 An in_valid write SHALL update out_pm on the next rising edge and assert out_valid in that same cycle (latency 1).
REQ-022 With in_valid low and frame_start low, out_pm SHALL hold its value and out_valid SHALL be 0.
REQ-023 norm_pending SHALL be a register that is set on the cycle after min_valid rises, if min_pm >= NORM_THRESH at that point.
REQ-024 A write with norm_pending set SHALL store each element as max(in_pm[i]-NORM_THRESH, 0), except that INF elements are stored unchanged as INF.
REQ-025 A normalized write SHALL clear norm_pending and pulse norm_event together with out_valid.
REQ-026 Without norm_pending, a write SHALL store in_pm unchanged.
REQ-027 The subtraction SHALL never wrap: results are floored at 0 and stay within PM_W bits.
REQ-028 Min search SHALL be a registered reduction over out_pm.
REQ-029 min_valid SHALL drop in the cycle out_pm changes, whether by write or by frame_start.
REQ-030 min_valid SHALL rise exactly one cycle after out_pm changes, with min_pm and min_state updated at the same time.
REQ-031 Min ties SHALL resolve to the lowest state index.
REQ-032 If all states are INF, min_pm SHALL be INF and min_state SHALL be 0.
REQ-033 step_cnt SHALL increment on each stored in_valid write and saturate at 0xFFFF.
REQ-034 Back-to-back in_valid writes on consecutive cycles SHALL all be stored; min_valid stays low until one idle cycle follows the last write.
REQ-035 A write in the cycle norm_pending sets SHALL be stored unnormalized; normalization applies from the following write.

Reset
REQ-036 rst SHALL override frame_start and in_valid.
REQ-037 During rst, out_pm SHALL take the seed values, step_cnt and norm_pending SHALL clear, and out_valid and norm_event SHALL be 0.
REQ-038 min_pm and min_state SHALL be 0 in the cycle after rst deasserts, with min_valid rising in that cycle.
REQ-039 rst asserted mid-frame SHALL discard all stored state within one cycle.

Verification (NUM_STATES=4, PM_W=4, NORM_THRESH=8, INF=15)
REQ-040 Reset then idle -> out_pm={15,15,15,0} (s3..s0); min_pm=0, min_state=0, min_valid=1 one cycle after rst deasserts.
REQ-041 in_valid with s3..s0={5,3,3,7} -> out_valid pulses next cycle; one cycle later min_pm=3, min_state=1.
REQ-042 Store {9,12,10,11}, idle 2 cycles, then write {10,15,9,13} -> stored {2,15,1,5}, norm_event=1, step_cnt=2.
REQ-043 frame_start and in_valid in the same cycle -> seed values stored, out_valid=0, step_cnt=0.
REQ-044 Three back-to-back writes followed by one idle cycle -> step_cnt=3, out_valid high for 3 cycles, min_valid low until the cycle after the last write plus one.
REQ-045 rst pulsed between two writes -> seed values restored, norm_pending cleared, no norm_event on the next write.

Source files
------------

// File: rtl/pmsm_param.sv
// Path-metric store for a Viterbi ACS datapath: holds one metric per trellis
// state, normalizes metrics when all of them have grown past a threshold, and
// keeps a registered minimum search over the stored metrics.
// Latency: a write appears on out_pm one cycle after in_valid. min_* settle one
// cycle after that.
// Backpressure: none. Every in_valid is accepted except when frame_start or rst
// is asserted in the same cycle.
//
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   frame_start     - reload seed metrics, clear step count and pending normalization
//   in_valid, in_pm - one ACS step result (state i at bits [i*PM_W +: PM_W])
//   out_pm          - stored metrics, packed like in_pm
//   out_valid       - one-cycle pulse when out_pm was updated by a write
//   min_pm          - smallest stored metric
//   min_state       - lowest state index holding min_pm
//   min_valid       - min_pm/min_state reflect the current out_pm
//   norm_event      - one-cycle pulse when the stored write was normalized
//   step_cnt        - writes stored since frame start (saturating)
module pmsm_param #(
  parameter int NUM_STATES  = 4,
  parameter int PM_W        = 4,
  parameter int NORM_THRESH = 8,
  parameter int INIT_STATE  = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_start,
  input  logic                           in_valid,
  input  logic [NUM_STATES*PM_W-1:0]     in_pm,
  output logic [NUM_STATES*PM_W-1:0]     out_pm,
  output logic                           out_valid,
  output logic [PM_W-1:0]                min_pm,
  output logic [$clog2(NUM_STATES)-1:0]  min_state,
  output logic                           min_valid,
  output logic                           norm_event,
  output logic [15:0]                    step_cnt
);

  localparam int SW = $clog2(NUM_STATES);

  // All-ones marks an unreachable state; it is never normalized.
  localparam logic [PM_W-1:0] INF = '1;
  localparam logic [PM_W-1:0] THR = PM_W'(NORM_THRESH);

  logic [NUM_STATES*PM_W-1:0] seed_pm;
  logic [NUM_STATES*PM_W-1:0] norm_pm;
  logic [NUM_STATES*PM_W-1:0] wr_pm;

  logic [PM_W-1:0] red_pm;
  logic [SW-1:0]   red_state;

  logic norm_pending;
  logic min_valid_q;   // min_valid one cycle ago, for rise detection
  logic min_rise;
  logic norm_set;

  // Per-state seed and normalized value of the incoming metric.
  for (genvar g = 0; g < NUM_STATES; g++) begin : g_state
    logic [PM_W-1:0] elem;

    assign elem = in_pm[g*PM_W +: PM_W];

    assign seed_pm[g*PM_W +: PM_W] = (g == INIT_STATE) ? '0 : INF;

    // Floor at zero instead of wrapping; unreachable states stay unreachable.
    assign norm_pm[g*PM_W +: PM_W] = (elem == INF) ? INF :
                                     (elem >= THR) ? (elem - THR) : '0;
  end

  assign wr_pm = norm_pending ? norm_pm : in_pm;

  // Linear reduction; strict less-than keeps the lowest index on ties, and
  // an all-INF store reports INF at state 0.
  always_comb begin
    red_pm    = out_pm[PM_W-1:0];
    red_state = '0;
    for (int i = 1; i < NUM_STATES; i++) begin
      if (out_pm[i*PM_W +: PM_W] < red_pm) begin
        red_pm    = out_pm[i*PM_W +: PM_W];
        red_state = SW'(i);
      end
    end
  end

  // The minimum is first trusted the cycle after min_valid rises; only then
  // is it compared against the threshold to arm normalization.
  assign min_rise = min_valid & ~min_valid_q;
  assign norm_set = min_rise && (min_pm >= THR);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_pm       <= seed_pm;
      out_valid    <= 1'b0;
      norm_event   <= 1'b0;
      step_cnt     <= '0;
      norm_pending <= 1'b0;
      min_pm       <= '0;
      min_state    <= '0;
      min_valid    <= 1'b0;
      min_valid_q  <= 1'b0;
    end else begin
      out_valid   <= 1'b0;
      norm_event  <= 1'b0;
      min_pm      <= red_pm;
      min_state   <= red_state;
      min_valid_q <= min_valid;

      if (frame_start) begin
        // Frame start wins over a simultaneous write; the write is dropped.
        out_pm       <= seed_pm;
        step_cnt     <= '0;
        norm_pending <= 1'b0;
        min_valid    <= 1'b0;
      end else if (in_valid) begin
        out_pm     <= wr_pm;
        out_valid  <= 1'b1;
        norm_event <= norm_pending;
        min_valid  <= 1'b0;
        if (step_cnt != 16'hFFFF) begin
          step_cnt <= step_cnt + 16'd1;
        end
        // A normalized write consumes the pending flag. A write landing in
        // the same cycle the flag arms is stored raw, and the flag still arms.
        if (norm_pending) begin
          norm_pending <= 1'b0;
        end else if (norm_set) begin
          norm_pending <= 1'b1;
        end
      end else begin
        min_valid <= 1'b1;
        if (norm_set) begin
          norm_pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pmsm_param.sv
module tb_pmsm_param;
  localparam int N   = 4;
  localparam int W   = 4;
  localparam int TH  = 8;
  localparam int INF = 15;

  logic        clk = 1'b0;
  logic        rst, frame_start, in_valid;
  logic [15:0] in_pm;
  logic [15:0] out_pm;
  logic        out_valid;
  logic [3:0]  min_pm;
  logic [1:0]  min_state;
  logic        min_valid;
  logic        norm_event;
  logic [15:0] step_cnt;

  pmsm_param #(.NUM_STATES(N), .PM_W(W), .NORM_THRESH(TH), .INIT_STATE(0)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
    .in_pm(in_pm), .out_pm(out_pm), .out_valid(out_valid), .min_pm(min_pm),
    .min_state(min_state), .min_valid(min_valid), .norm_event(norm_event),
    .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: metric array, edges since the store last changed,
  // pending-normalization flag, write count, and the two pulses.
  int m_pm[N];
  int m_age;
  bit m_pend;
  int m_steps;
  bit m_ov, m_nev;

  function automatic int m_min_val();
    int v = m_pm[0];
    for (int i = 1; i < N; i++) if (m_pm[i] < v) v = m_pm[i];
    return v;
  endfunction

  function automatic int m_min_idx();
    int v = m_pm[0];
    int k = 0;
    for (int i = 1; i < N; i++) if (m_pm[i] < v) begin v = m_pm[i]; k = i; end
    return k;
  endfunction

  function automatic logic [15:0] m_packed();
    logic [15:0] p = '0;
    for (int i = 0; i < N; i++) p[i*W +: W] = 4'(m_pm[i]);
    return p;
  endfunction

  function automatic void m_seed();
    for (int i = 0; i < N; i++) m_pm[i] = (i == 0) ? 0 : INF;
  endfunction

  function automatic void model_step(input bit r, input bit fs, input bit iv, input logic [15:0] d);
    bit rise;
    int mn;
    int e;
    m_ov = 0; m_nev = 0;
    if (r) begin
      m_seed(); m_age = 0; m_pend = 0; m_steps = 0;
      return;
    end
    // min_valid became visible one edge ago, so the minimum is examined now.
    rise = (m_age == 1);
    mn = m_min_val();
    if (fs) begin
      m_seed(); m_age = 0; m_pend = 0; m_steps = 0;
    end else if (iv) begin
      for (int i = 0; i < N; i++) begin
        e = int'(d[i*W +: W]);
        if (m_pend && e != INF) e = (e >= TH) ? e - TH : 0;
        m_pm[i] = e;
      end
      m_ov = 1;
      m_nev = m_pend;
      if (m_steps < 65535) m_steps++;
      m_age = 0;
      if (m_pend) m_pend = 0;
      else if (rise && mn >= TH) m_pend = 1;
    end else begin
      if (m_age < 2) m_age++;
      if (rise && mn >= TH) m_pend = 1;
    end
  endfunction

  task automatic tick(input bit r, input bit fs, input bit iv, input logic [15:0] d);
    rst = r; frame_start = fs; in_valid = iv; in_pm = d;
    @(posedge clk);
    #1;
    model_step(r, fs, iv, d);
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 16'h0);
    tick(1, 1, 1, 16'h1234);
    n_checks++; if (out_pm !== 16'hFFF0) $display("FAIL rst_pm: got %h want fff0", out_pm); else n_pass++;
    n_checks++; if (min_valid !== 1'b0) $display("FAIL rst_minv: got %b want 0", min_valid); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_ov: got %b want 0", out_valid); else n_pass++;
    tick(0, 0, 0, 16'h0);
    n_checks++; if (out_pm !== 16'hFFF0) $display("FAIL post_rst_pm: got %h want fff0", out_pm); else n_pass++;
    n_checks++; if (min_valid !== 1'b1) $display("FAIL post_rst_minv: got %b want 1", min_valid); else n_pass++;
    n_checks++; if (min_pm !== 4'd0 || min_state !== 2'd0) $display("FAIL post_rst_min: got %0d/%0d want 0/0", min_pm, min_state); else n_pass++;
    n_checks++; if (step_cnt !== 16'd0) $display("FAIL post_rst_steps: got %0d want 0", step_cnt); else n_pass++;
  endtask

  task automatic test_write();
    tick(0, 0, 1, 16'h5337);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL wr_ov: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_pm !== 16'h5337) $display("FAIL wr_pm: got %h want 5337", out_pm); else n_pass++;
    n_checks++; if (min_valid !== 1'b0) $display("FAIL wr_minv_drop: got %b want 0", min_valid); else n_pass++;
    tick(0, 0, 0, 16'h0);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL wr_ov_idle: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (min_valid !== 1'b1) $display("FAIL wr_minv_rise: got %b want 1", min_valid); else n_pass++;
    n_checks++; if (min_pm !== 4'd3 || min_state !== 2'd1) $display("FAIL wr_min_tie: got %0d/%0d want 3/1", min_pm, min_state); else n_pass++;
  endtask

  task automatic test_norm();
    tick(0, 1, 0, 16'h0);
    tick(0, 0, 1, 16'h9CAB);
    tick(0, 0, 0, 16'h0);
    tick(0, 0, 0, 16'h0);
    tick(0, 0, 1, 16'hAF9D);
    n_checks++; if (out_pm !== 16'h2F15) $display("FAIL norm_pm: got %h want 2f15", out_pm); else n_pass++;
    n_checks++; if (norm_event !== 1'b1 || out_valid !== 1'b1) $display("FAIL norm_evt: got %b%b want 11", norm_event, out_valid); else n_pass++;
    n_checks++; if (step_cnt !== 16'd2) $display("FAIL norm_steps: got %0d want 2", step_cnt); else n_pass++;
    tick(0, 0, 0, 16'h0);
    n_checks++; if (norm_event !== 1'b0) $display("FAIL norm_evt_pulse: got %b want 0", norm_event); else n_pass++;
    n_checks++; if (min_pm !== 4'd1 || min_state !== 2'd1) $display("FAIL norm_min: got %0d/%0d want 1/1", min_pm, min_state); else n_pass++;
    // Write landing on the edge where normalization arms is stored raw.
    tick(0, 0, 1, 16'h9CAB);
    tick(0, 0, 0, 16'h0);
    tick(0, 0, 1, 16'hAF9D);
    n_checks++; if (out_pm !== 16'hAF9D || norm_event !== 1'b0) $display("FAIL arm_raw: got %h/%b want af9d/0", out_pm, norm_event); else n_pass++;
    tick(0, 0, 1, 16'h9CAB);
    n_checks++; if (out_pm !== 16'h1423 || norm_event !== 1'b1) $display("FAIL arm_next: got %h/%b want 1423/1", out_pm, norm_event); else n_pass++;
  endtask

  task automatic test_frame_start();
    tick(0, 1, 1, 16'h1234);
    n_checks++; if (out_pm !== 16'hFFF0) $display("FAIL fs_pm: got %h want fff0", out_pm); else n_pass++;
    n_checks++; if (out_valid !== 1'b0 || norm_event !== 1'b0) $display("FAIL fs_pulses: got %b%b want 00", out_valid, norm_event); else n_pass++;
    n_checks++; if (step_cnt !== 16'd0) $display("FAIL fs_steps: got %0d want 0", step_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] d[3];
    d[0] = 16'h1111; d[1] = 16'h2222; d[2] = 16'h0123;
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 1, d[k]);
      n_checks++; if (out_valid !== 1'b1 || min_valid !== 1'b0) $display("FAIL b2b_%0d: got ov=%b minv=%b want 1/0", k, out_valid, min_valid); else n_pass++;
    end
    n_checks++; if (step_cnt !== 16'd3 || out_pm !== 16'h0123) $display("FAIL b2b_end: got %0d/%h want 3/0123", step_cnt, out_pm); else n_pass++;
    tick(0, 0, 0, 16'h0);
    n_checks++; if (min_valid !== 1'b1 || min_pm !== 4'd0 || min_state !== 2'd3) $display("FAIL b2b_min: got %b/%0d/%0d want 1/0/3", min_valid, min_pm, min_state); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    tick(0, 1, 0, 16'h0);
    tick(0, 0, 1, 16'h9CAB);
    tick(0, 0, 0, 16'h0);
    tick(0, 0, 0, 16'h0);
    tick(1, 0, 1, 16'h0000);
    n_checks++; if (out_pm !== 16'hFFF0 || step_cnt !== 16'd0) $display("FAIL mid_rst: got %h/%0d want fff0/0", out_pm, step_cnt); else n_pass++;
    tick(0, 0, 1, 16'hAF9D);
    n_checks++; if (out_pm !== 16'hAF9D || norm_event !== 1'b0) $display("FAIL mid_rst_wr: got %h/%b want af9d/0", out_pm, norm_event); else n_pass++;
    n_checks++; if (step_cnt !== 16'd1) $display("FAIL mid_rst_steps: got %0d want 1", step_cnt); else n_pass++;
  endtask

  task automatic test_random();
    bit r, fs, iv;
    logic [15:0] d;
    for (int c = 0; c < 600; c++) begin
      r  = ($urandom_range(0, 99) < 2);
      fs = ($urandom_range(0, 99) < 4);
      iv = ($urandom_range(0, 99) < 50);
      for (int i = 0; i < N; i++) d[i*W +: W] = 4'($urandom_range(5, 15));
      tick(r, fs, iv, d);
      n_checks++; if (out_pm !== m_packed()) $display("FAIL rnd_pm c%0d: got %h want %h", c, out_pm, m_packed()); else n_pass++;
      n_checks++; if (out_valid !== m_ov || norm_event !== m_nev) $display("FAIL rnd_pulses c%0d: got %b%b want %b%b", c, out_valid, norm_event, m_ov, m_nev); else n_pass++;
      n_checks++; if (step_cnt !== 16'(m_steps)) $display("FAIL rnd_steps c%0d: got %0d want %0d", c, step_cnt, m_steps); else n_pass++;
      n_checks++; if (min_valid !== (m_age >= 1)) $display("FAIL rnd_minv c%0d: got %b want %b", c, min_valid, (m_age >= 1)); else n_pass++;
      if (m_age >= 1) begin
        n_checks++;
        if (min_pm !== 4'(m_min_val()) || min_state !== 2'(m_min_idx()))
          $display("FAIL rnd_min c%0d: got %0d/%0d want %0d/%0d", c, min_pm, min_state, m_min_val(), m_min_idx());
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; in_valid = 1'b0; in_pm = '0;
    m_seed(); m_age = 0; m_pend = 0; m_steps = 0; m_ov = 0; m_nev = 0;
    test_reset();
    test_write();
    test_norm();
    test_frame_start();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
